// File: rtl/sync_read_pointer_status.sv
// sync_read_pointer_status: write-side Gray read-pointer synchroniser with fill level, full/almost_full and CDC fault flags
//   write_clk, write_reset      : write-domain clock, synchronous active-high reset
//   read_pointer                : Gray read pointer from the read domain (asynchronous)
//   write_pointer_bin           : local binary write pointer
//   error_clear                 : clears sticky gray_error / level_error (a new fault wins)
//   write_to_read_pointer       : synchronised Gray pointer (last chain stage)
//   read_pointer_bin            : registered binary form of write_to_read_pointer
//   update_pulse                : synchronised pointer changed since the previous sample
//   fill_level, full, almost_full : registered together from one subtraction
//   gray_error, level_error     : sticky CDC integrity flags
module sync_read_pointer_status #(
  parameter int address_size       = 3,
  parameter int SYNC_STAGES        = 2,
  parameter int ALMOST_FULL_MARGIN = 1
) (
  input  logic                    write_clk,
  input  logic                    write_reset,
  input  logic [address_size:0]   read_pointer,
  input  logic [address_size:0]   write_pointer_bin,
  input  logic                    error_clear,
  output logic [address_size:0]   write_to_read_pointer,
  output logic [address_size:0]   read_pointer_bin,
  output logic                    update_pulse,
  output logic [address_size:0]   fill_level,
  output logic                    full,
  output logic                    almost_full,
  output logic                    gray_error,
  output logic                    level_error
);
  localparam int W = address_size + 1;
  localparam int DEPTH = 1 << address_size;
  localparam logic [W-1:0] DEPTH_W = W'(DEPTH);
  localparam logic [W-1:0] AF_W = W'(DEPTH - ALMOST_FULL_MARGIN);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("SYNC_STAGES must be in 2..4");
  end
  if (ALMOST_FULL_MARGIN < 0 || ALMOST_FULL_MARGIN >= DEPTH) begin : g_bad_margin
    $error("ALMOST_FULL_MARGIN must be in 0..DEPTH-1");
  end
  logic [W-1:0] stage_q [SYNC_STAGES];
  logic [W-1:0] prev_gray_q, rbin_q, fill_q;
  logic         update_q, full_q, almost_full_q, gray_err_q, level_err_q;
  logic [W-1:0] sync_gray, rbin_d, diff_d;
  logic         gray_set_d, level_set_d;
  assign sync_gray = stage_q[SYNC_STAGES-1];
  always_comb begin
    rbin_d = '0;
    for (int k = 0; k < W; k++) rbin_d[k] = ^(sync_gray >> k);
    diff_d = write_pointer_bin - rbin_q;
    gray_set_d = $countones(sync_gray ^ prev_gray_q) > 1;
    level_set_d = diff_d > DEPTH_W;
  end
  always_ff @(posedge write_clk) begin
    if (write_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      prev_gray_q   <= '0;
      rbin_q        <= '0;
      update_q      <= 1'b0;
      fill_q        <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      gray_err_q    <= 1'b0;
      level_err_q   <= 1'b0;
    end else begin
      stage_q[0] <= read_pointer;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      prev_gray_q   <= sync_gray;
      rbin_q        <= rbin_d;
      update_q      <= sync_gray != prev_gray_q;
      fill_q        <= diff_d;
      full_q        <= diff_d >= DEPTH_W;
      almost_full_q <= diff_d >= AF_W;
      gray_err_q    <= gray_set_d | (gray_err_q & ~error_clear);
      level_err_q   <= level_set_d | (level_err_q & ~error_clear);
    end
  end
  assign write_to_read_pointer = sync_gray;
  assign read_pointer_bin      = rbin_q;
  assign update_pulse          = update_q;
  assign fill_level            = fill_q;
  assign full                  = full_q;
  assign almost_full           = almost_full_q;
  assign gray_error            = gray_err_q;
  assign level_error           = level_err_q;
endmodule

// File: tb/tb_sync_read_pointer_status.sv
// tb_sync_read_pointer_status: directed and randomized checks against a latency-level reference model
module tb_sync_read_pointer_status;
  localparam int AS = 3;
  localparam int N = 2;
  localparam int M = 1;
  localparam int W = AS + 1;
  localparam int DEPTH = 1 << AS;
  logic clk = 1'b0;
  logic rst, clr;
  logic [W-1:0] rp, wb;
  logic [W-1:0] wtr, rbin, fill;
  logic upd, full, af, gerr, lerr;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] hist [N];
  logic [W-1:0] m_prev, m_rbin, m_fill;
  logic m_upd, m_full, m_af, m_gerr, m_lerr;
  sync_read_pointer_status #(.address_size(AS), .SYNC_STAGES(N), .ALMOST_FULL_MARGIN(M)) dut (
    .write_clk(clk), .write_reset(rst), .read_pointer(rp), .write_pointer_bin(wb),
    .error_clear(clr), .write_to_read_pointer(wtr), .read_pointer_bin(rbin),
    .update_pulse(upd), .fill_level(fill), .full(full), .almost_full(af),
    .gray_error(gerr), .level_error(lerr));
  always #5 clk = ~clk;
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int i = 1; i < W; i++) b = b ^ (g >> i);
    return b;
  endfunction
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model();
    logic [W-1:0] s, diff;
    if (rst) begin
      for (int i = 0; i < N; i++) hist[i] = '0;
      {m_prev, m_rbin, m_fill} = '0;
      {m_upd, m_full, m_af, m_gerr, m_lerr} = '0;
    end else begin
      s = hist[N-1];
      diff = wb - m_rbin;
      m_upd = s != m_prev;
      m_gerr = ($countones(s ^ m_prev) > 1) ? 1'b1 : (clr ? 1'b0 : m_gerr);
      m_prev = s;
      m_rbin = g2b(s);
      m_fill = diff;
      m_full = int'(diff) >= DEPTH;
      m_af = int'(diff) >= DEPTH - M;
      m_lerr = (int'(diff) > DEPTH) ? 1'b1 : (clr ? 1'b0 : m_lerr);
      for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = rp;
    end
  endtask
  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("wtr", wtr, hist[N-1]);
    chk("rbin", rbin, m_rbin);
    chk("update_pulse", W'(upd), W'(m_upd));
    chk("fill_level", fill, m_fill);
    chk("full", W'(full), W'(m_full));
    chk("almost_full", W'(af), W'(m_af));
    chk("gray_error", W'(gerr), W'(m_gerr));
    chk("level_error", W'(lerr), W'(m_lerr));
  endtask
  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  initial begin
    rst = 1'b1; clr = 1'b0; rp = 4'b0110; wb = '0;
    steps(3);
    chk("reset_outputs", {wtr[0] | rbin[0] | fill[0], upd, full, af, gerr | lerr}, '0);
    chk("reset_wtr", wtr, '0);
    rst = 1'b0;
    steps(2);
    chk("release_wtr", wtr, 4'b0110);
    step();
    chk("release_rbin", rbin, 4'b0100);
    rp = 4'b0000; wb = 4'd4; clr = 1'b1;
    steps(4);
    clr = 1'b0;
    steps(2);
    rp = 4'b0001;
    steps(2);
    chk("lat_wtr", wtr, 4'b0001);
    step();
    chk("lat_rbin", rbin, 4'd1);
    chk("lat_upd", W'(upd), 4'd1);
    step();
    chk("lat_fill", fill, 4'd3);
    chk("lat_upd_drop", W'(upd), 4'd0);
    rp = 4'b0000;
    steps(4);
    wb = 4'd8; step();
    chk("thr8", {fill[3:0]}, 4'd8); chk("thr8_flags", W'({full, af}), 4'b0011);
    wb = 4'd7; step();
    chk("thr7", fill, 4'd7); chk("thr7_flags", W'({full, af}), 4'b0001);
    wb = 4'd6; step();
    chk("thr6", fill, 4'd6); chk("thr6_flags", W'({full, af}), 4'b0000);
    rp = 4'b1111; wb = 4'd2;
    steps(4);
    chk("wrap_rbin", rbin, 4'd10);
    chk("wrap_fill", fill, 4'd8);
    chk("wrap_full", W'(full), 4'd1);
    chk("wrap_lerr", W'(lerr), 4'd0);
    rp = 4'b0000; wb = 4'd0;
    steps(4);
    clr = 1'b1; step(); clr = 1'b0;
    rp = 4'b0011;
    steps(3);
    chk("gerr_set", W'(gerr), 4'd1);
    steps(2);
    chk("gerr_sticky", W'(gerr), 4'd1);
    clr = 1'b1; step();
    chk("gerr_clear", W'(gerr), 4'd0);
    rp = 4'b0000;
    steps(3);
    chk("gerr_set_beats_clear", W'(gerr), 4'd1);
    clr = 1'b0;
    steps(2);
    wb = 4'd12; step();
    chk("lerr_set", W'(lerr), 4'd1);
    chk("lerr_full", W'(full), 4'd1);
    rst = 1'b1; step();
    chk("midrst_flags", W'({upd, full, af, gerr, lerr}), 4'd0);
    chk("midrst_fill", fill, 4'd0);
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(3))
        0: rp = W'($urandom);
        1: rp = (g2b(rp) + 1'b1) ^ ((g2b(rp) + 1'b1) >> 1);
        default: ;
      endcase
      wb = ($urandom_range(3) == 0) ? W'($urandom) : wb + W'($urandom_range(1));
      clr = $urandom_range(9) == 0;
      rst = $urandom_range(49) == 0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
